sim_status_ctrl: RTL and testbench

Parametrised end-of-simulation controller for the Verilator top-level bench. It watches N RVFI/monitor commit channels plus the memory-model and monitor error flags. It sequences a clean stop (halt, then a drain window so in-flight DRAM bursts retire) or a latched failure with a cause code. It also maintains commit and cycle counters for IPC reporting. It replaces the purely combinational halt/error OR-reduction in the bench top.

---
 rtl/sim_status_pkg.sv | 24 ++
 rtl/sim_popcount.sv | 19 +
 rtl/sim_status_ctrl.sv | 143 ++++++++++++++
 tb/tb_sim_status_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/sim_status_pkg.sv
// Shared types for the end-of-simulation controller: FSM states, failure
// causes and a small width helper for the internal down/idle counters.
package sim_status_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2,
    FAIL  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_MEM     = 2'd1,
    CAUSE_MON     = 2'd2,
    CAUSE_TIMEOUT = 2'd3
  } cause_e;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sim_popcount.sv
// Combinational population count of a WIDTH-bit vector; used to turn the
// per-lane commit strobes into a per-cycle commit count.
module sim_popcount #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0]             bits_i,
  output logic [$clog2(WIDTH+1)-1:0]   count_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  always_comb begin
    count_o = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      count_o = count_o + CW'(bits_i[i]);
    end
  end

endmodule

// File: rtl/sim_status_ctrl.sv
// End-of-simulation controller: clean halt with a drain window, or a latched
// failure with cause code; counts commits and cycles. Optional idle timeout
// is compiled in when SIM_STATUS_TIMEOUT_EN is defined.
module sim_status_ctrl
  import sim_status_pkg::*;
#(
  parameter int unsigned CHANNELS       = 8,
  parameter int unsigned DRAIN_CYCLES   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned CNT_W          = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] commit_valid,
  input  logic [CHANNELS-1:0] chan_halt,
  input  logic                mem_error,
  input  logic                mon_error,
  output logic                halt,
  output logic                error,
  output logic [1:0]          cause,
  output logic [CNT_W-1:0]    commits,
  output logic [CNT_W-1:0]    cycles
);

  localparam int unsigned PW = $clog2(CHANNELS + 1);
  localparam int unsigned DW = cnt_width(DRAIN_CYCLES);

  state_e           state_q, state_d;
  cause_e           cause_q, cause_d;
  logic [CNT_W-1:0] commits_q, commits_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [PW-1:0]    pop;
  logic             any_commit;
  logic             halt_hit;
  logic             ext_err;
  cause_e           err_cause;
  logic             timeout;

  sim_popcount #(
    .WIDTH(CHANNELS)
  ) u_popcount (
    .bits_i (commit_valid),
    .count_o(pop)
  );

  always_comb begin
    any_commit = |commit_valid;
    halt_hit   = |(chan_halt & commit_valid);
    ext_err    = mem_error | mon_error;
    err_cause  = mem_error ? CAUSE_MEM : CAUSE_MON;
  end

`ifdef SIM_STATUS_TIMEOUT_EN
  localparam int unsigned IW = cnt_width(TIMEOUT_CYCLES);

  logic [IW-1:0] idle_q, idle_d;

  // Idle counter saturates at TIMEOUT_CYCLES-1; the next idle cycle fires.
  always_comb begin
    idle_d  = idle_q;
    timeout = 1'b0;
    if (state_q == RUN) begin
      if (any_commit) begin
        idle_d = '0;
      end else begin
        timeout = (idle_q == IW'(TIMEOUT_CYCLES - 1));
        if (!timeout) idle_d = idle_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) idle_q <= '0;
    else     idle_q <= idle_d;
  end
`else
  always_comb timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    commits_d = commits_q;
    cycles_d  = cycles_q;
    drain_d   = drain_q;
    unique case (state_q)
      RUN: begin
        cycles_d  = cycles_q + 1'b1;
        commits_d = commits_q + CNT_W'(pop);
        // External error outranks timeout, which outranks halt.
        if (ext_err) begin
          state_d = FAIL;
          cause_d = err_cause;
        end else if (timeout) begin
          state_d = FAIL;
          cause_d = CAUSE_TIMEOUT;
        end else if (halt_hit) begin
          state_d = DRAIN;
          drain_d = DW'(DRAIN_CYCLES - 1);
        end
      end
      DRAIN: begin
        cycles_d = cycles_q + 1'b1;
        if (ext_err) begin
          state_d = FAIL;
          cause_d = err_cause;
        end else if (drain_q == '0) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      DONE, FAIL: ;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      cause_q   <= CAUSE_NONE;
      commits_q <= '0;
      cycles_q  <= '0;
      drain_q   <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      commits_q <= commits_d;
      cycles_q  <= cycles_d;
      drain_q   <= drain_d;
    end
  end

  always_comb begin
    halt    = (state_q == DONE);
    error   = (state_q == FAIL);
    cause   = cause_q;
    commits = commits_q;
    cycles  = cycles_q;
  end

endmodule

// File: tb/tb_sim_status_ctrl.sv
// Scoreboard bench for sim_status_ctrl: directed stimulus pushes cycle-tagged
// expected outputs, a negedge monitor pops and compares them.
module tb_sim_status_ctrl;

  logic        clk;
  logic        rst;
  logic [7:0]  commit_valid;
  logic [7:0]  chan_halt;
  logic        mem_error;
  logic        mon_error;
  logic        halt;
  logic        error;
  logic [1:0]  cause;
  logic [63:0] commits;
  logic [63:0] cycles;

  sim_status_ctrl #(
    .CHANNELS      (8),
    .DRAIN_CYCLES  (16),
    .TIMEOUT_CYCLES(50),
    .CNT_W         (64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .commit_valid(commit_valid),
    .chan_halt   (chan_halt),
    .mem_error   (mem_error),
    .mon_error   (mon_error),
    .halt        (halt),
    .error       (error),
    .cause       (cause),
    .commits     (commits),
    .cycles      (cycles)
  );

  typedef struct {
    int          at;
    string       name;
    logic        h;
    logic        e;
    logic [1:0]  c;
    logic [63:0] cm;
    logic [63:0] cy;
  } exp_t;

  exp_t sb[$];
  exp_t r;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      r = sb.pop_front();
      checks++;
      if (r.at < cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", r.name, r.at, cyc);
      end else if (halt !== r.h || error !== r.e || cause !== r.c ||
                   commits !== r.cm || cycles !== r.cy) begin
        errors++;
        $display("FAIL %s: got halt=%0b error=%0b cause=%0d commits=%0d cycles=%0d, want halt=%0b error=%0b cause=%0d commits=%0d cycles=%0d",
                 r.name, halt, error, cause, commits, cycles, r.h, r.e, r.c, r.cm, r.cy);
      end
    end
  end

  task automatic drive(input logic rs, input logic [7:0] cv, input logic [7:0] ch,
                       input logic me, input logic mo);
    rst = rs; commit_valid = cv; chan_halt = ch; mem_error = me; mon_error = mo;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic exp_out(input string nm, input logic h, input logic e, input logic [1:0] c,
                         input logic [63:0] cm, input logic [63:0] cy);
    exp_t x;
    x.at = cyc; x.name = nm; x.h = h; x.e = e; x.c = c; x.cm = cm; x.cy = cy;
    sb.push_back(x);
  endtask

  initial begin
    rst = 1'b1; commit_valid = '0; chan_halt = '0; mem_error = 1'b0; mon_error = 1'b0;

    // Reset, then lanes 0..3 commit for 10 cycles and lane 2 halts.
    drive(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
    exp_out("reset", 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 8'h0F, 8'h00, 1'b0, 1'b0);
      if (i == 0) exp_out("run_first", 0, 0, 0, 4, 1);
    end
    exp_out("run_10", 0, 0, 0, 40, 10);
    drive(1'b0, 8'h0F, 8'h04, 1'b0, 1'b0);
    exp_out("halt_sample", 0, 0, 0, 44, 11);
    for (int k = 1; k <= 16; k++) begin
      drive(1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0);
      if (k == 1)  exp_out("drain_ignore", 0, 0, 0, 44, 12);
      if (k == 15) exp_out("drain_last", 0, 0, 0, 44, 26);
      if (k == 16) exp_out("halt_rise", 1, 0, 0, 44, 27);
    end
    drive(1'b0, 8'hFF, 8'h00, 1'b1, 1'b1);
    exp_out("done_frozen", 1, 0, 0, 44, 27);

    // Simultaneous mem and mon error: mem wins, counters freeze.
    drive(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
    exp_out("reset2", 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(1'b0, 8'h01, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 8'h03, 8'h00, 1'b1, 1'b1);
    exp_out("dual_err", 0, 1, 1, 7, 6);
    drive(1'b0, 8'hFF, 8'hFF, 1'b0, 1'b1);
    drive(1'b0, 8'hFF, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    exp_out("fail_frozen", 0, 1, 1, 7, 6);

    // Halt and monitor error together: error wins.
    drive(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 8'h0F, 8'h01, 1'b0, 1'b1);
    exp_out("halt_vs_mon", 0, 1, 2, 4, 1);
    idle(20);
    exp_out("no_halt", 0, 1, 2, 4, 1);

    // chan_halt without same-lane commit does not start a drain.
    drive(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b0, 8'h07, 8'h08, 1'b0, 1'b0);
    exp_out("unqual_halt", 0, 0, 0, 60, 20);

    // Error during the drain window.
    drive(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 8'h01, 8'h01, 1'b0, 1'b0);
    exp_out("drain_start", 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) drive(1'b0, 8'hFF, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 8'hFF, 8'h00, 1'b1, 1'b0);
    exp_out("drain_err", 0, 1, 1, 1, 5);

    // Reset in DRAIN cycle 3, then a full halt sequence.
    drive(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 8'hFF, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 8'hFF, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 8'h80, 8'h80, 1'b0, 1'b0);
    exp_out("pre_drain", 0, 0, 0, 17, 3);
    idle(2);
    drive(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
    exp_out("rst_drain", 0, 0, 0, 0, 0);
    drive(1'b0, 8'hFF, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 8'hFF, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 8'h80, 8'h80, 1'b0, 1'b0);
    exp_out("rehalt", 0, 0, 0, 17, 3);
    idle(15);
    exp_out("rehalt_wait", 0, 0, 0, 17, 18);
    idle(1);
    exp_out("rehalt_done", 1, 0, 0, 17, 19);

    // One commit then 50 idle cycles: timeout only when compiled in.
    drive(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 8'h01, 8'h00, 1'b0, 1'b0);
    idle(49);
    exp_out("idle_49", 0, 0, 0, 1, 50);
    idle(1);
`ifdef SIM_STATUS_TIMEOUT_EN
    exp_out("timeout", 0, 1, 3, 1, 51);
`else
    exp_out("no_timeout", 0, 0, 0, 1, 51);
`endif

    // External error on the would-be timeout cycle reports the monitor.
    drive(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
    idle(49);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    exp_out("err_over_timeout", 0, 1, 2, 0, 50);

    // A commit every 49 cycles never times out.
    drive(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'h01, 8'h00, 1'b0, 1'b0);
      idle(48);
    end
    drive(1'b0, 8'h01, 8'h00, 1'b0, 1'b0);
    exp_out("periodic", 0, 0, 0, 5, 197);

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
